// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and constants for the register-file access controller and the
// register array it drives.
package regfile_access_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_A    = 3'd1,
    RD_B    = 3'd2,
    CAP_B   = 3'd3,
    OPS     = 3'd4,
    WB_WAIT = 3'd5,
    WB      = 3'd6
  } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator for the multicycle core: reads rs/rt through one
// synchronous-read port, hands both operands to execute, then writes rd back.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int DATA_W = regfile_access_ctrl_pkg::DATA_W,
  parameter int ADDR_W = regfile_access_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] req_rt,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_wr,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] wb_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = RD_A;
      RD_A:    state_nxt = RD_B;
      RD_B:    state_nxt = CAP_B;
      CAP_B:   state_nxt = OPS;
      OPS:     if (op_ready) state_nxt = wr_q ? WB_WAIT : IDLE;
      WB_WAIT: if (wb_valid) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields and the writeback value only matter once the FSM has moved
  // past the state that loads them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      rs_q <= req_rs;
      rt_q <= req_rt;
      rd_q <= req_rd;
      wr_q <= req_wr;
    end
    if (state == WB_WAIT && wb_valid) wb_q <= wb_data;
  end

  // Read data lags the address by one cycle: rs data arrives in RD_B, rt in CAP_B.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else begin
      if (state == RD_B)  op_a <= (rs_q == ZERO_IDX) ? '0 : rf_rdata;
      if (state == CAP_B) op_b <= (rt_q == ZERO_IDX) ? '0 : rf_rdata;
    end
  end

  always_comb begin
    req_ready = 1'b0;
    op_valid  = 1'b0;
    wb_ready  = 1'b0;
    rf_addr   = '0;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:    req_ready = 1'b1;
      RD_A:    rf_addr   = rs_q;
      RD_B:    rf_addr   = rt_q;
      OPS:     op_valid  = 1'b1;
      WB_WAIT: wb_ready  = 1'b1;
      WB: begin
        rf_addr  = rd_q;
        rf_wdata = wb_q;
        rf_we    = (rd_q != ZERO_IDX);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural register array and
// queue-based scoreboards for operand transfers and register writes.
module tb_regfile_access_ctrl;
  import regfile_access_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_rs = '0, req_rt = '0, req_rd = '0;
  logic          req_wr = 1'b0;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [DW-1:0] op_a, op_b;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [DW-1:0] wb_data = '0;
  logic [AW-1:0] rf_addr;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem    [32];
  logic [DW-1:0] shadow [32];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_waddr = '0;
  logic [DW-1:0] tb_wdata = '0;

  logic [63:0]      exp_ops [$];
  logic [AW+DW-1:0] exp_wr  [$];
  logic [AW+DW-1:0] mon_w;

  regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_wr(req_wr),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Register array: synchronous read, bench-side preload port.
  always_ff @(posedge clk) begin
    rf_rdata <= mem[rf_addr];
    if (rf_we)      mem[rf_addr]  <= rf_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next expected write, one per pulse.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("rf_we_unexpected", 64'(rf_we), 64'(0));
      end else begin
        mon_w = exp_wr.pop_front();
        check("rf_wr_addr", 64'(rf_addr), 64'(mon_w[AW+DW-1:DW]));
        check("rf_wr_data", 64'(rf_wdata), 64'(mon_w[DW-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] idx, input logic [DW-1:0] v);
    tb_we = 1'b1; tb_waddr = idx; tb_wdata = v;
    tick();
    tb_we = 1'b0;
    shadow[idx] = v;
  endtask

  task automatic do_req(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic wr);
    check("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_rs = rs; req_rt = rt; req_rd = rd; req_wr = wr;
    exp_ops.push_back({(rs == 0) ? 32'h0 : shadow[rs], (rt == 0) ? 32'h0 : shadow[rt]});
    tick();
    req_valid = 1'b0; req_rs = '0; req_rt = '0; req_rd = '0; req_wr = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
    check("rd_a_addr", 64'(rf_addr), 64'(rs));
    tick();
    check("rd_b_addr", 64'(rf_addr), 64'(rt));
    tick();
    check("op_valid_early", 64'(op_valid), 64'(0));
    tick();
    check("op_valid_edge4", 64'(op_valid), 64'(1));
    check("ops_addr_zero", 64'(rf_addr), 64'(0));
  endtask

  task automatic do_ops(input int hold, input logic wr);
    logic [63:0] e;
    if (exp_ops.size() == 0) begin
      check("ops_queue_empty", 64'(exp_ops.size()), 64'(1));
      e = '0;
    end else begin
      e = exp_ops.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      check("op_valid_hold", 64'(op_valid), 64'(1));
      check("op_a_hold", 64'(op_a), 64'(e[63:32]));
      check("op_b_hold", 64'(op_b), 64'(e[31:0]));
      tick();
    end
    check("op_a", 64'(op_a), 64'(e[63:32]));
    check("op_b", 64'(op_b), 64'(e[31:0]));
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("op_valid_drop", 64'(op_valid), 64'(0));
    if (wr) check("wb_ready_after_ops", 64'(wb_ready), 64'(1));
    else    check("idle_after_ops", 64'(req_ready), 64'(1));
  endtask

  task automatic do_wb(input logic [DW-1:0] data, input logic [AW-1:0] rd);
    wb_valid = 1'b1; wb_data = data;
    if (rd != 0) exp_wr.push_back({rd, data});
    tick();
    wb_valid = 1'b0; wb_data = '0;
    check("wb_ready_in_wb", 64'(wb_ready), 64'(0));
    check("wb_rf_we", 64'(rf_we), 64'(rd != 0));
    check("wb_rf_addr", 64'(rf_addr), 64'(rd));
    check("wb_rf_wdata", 64'(rf_wdata), 64'(data));
    if (rd != 0) shadow[rd] = data;
    tick();
    check("wb_we_single", 64'(rf_we), 64'(0));
    check("idle_after_wb", 64'(req_ready), 64'(1));
    check("busy_after_wb", 64'(busy), 64'(0));
  endtask

  initial begin
    repeat (2) tick();
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rf_we", 64'(rf_we), 64'(0));
    check("rst_op_valid", 64'(op_valid), 64'(0));
    check("rst_wb_ready", 64'(wb_ready), 64'(0));
    check("rst_op_a", 64'(op_a), 64'(0));
    check("rst_op_b", 64'(op_b), 64'(0));
    check("rst_rf_addr", 64'(rf_addr), 64'(0));
    check("rst_rf_wdata", 64'(rf_wdata), 64'(0));
    rst = 1'b0;
    tick();
    check("idle_req_ready", 64'(req_ready), 64'(1));

    preload(5'd5, 32'h11);
    preload(5'd7, 32'h22);
    preload(5'd0, 32'hFFFF);

    // Basic read, operand transfer and writeback.
    do_req(5'd5, 5'd7, 5'd9, 1'b1);
    do_ops(0, 1'b1);
    do_wb(32'hDEADBEEF, 5'd9);

    // Read back R9 with rs==rt.
    do_req(5'd9, 5'd9, 5'd0, 1'b0);
    do_ops(0, 1'b0);

    // R0 reads as zero even with a non-zero array cell.
    do_req(5'd0, 5'd0, 5'd1, 1'b0);
    do_ops(0, 1'b0);

    // rd==0 writeback is consumed but never written.
    do_req(5'd5, 5'd7, 5'd0, 1'b1);
    do_ops(0, 1'b1);
    do_wb(32'h1234, 5'd0);

    // Backpressure on the operand handshake.
    do_req(5'd7, 5'd5, 5'd10, 1'b0);
    do_ops(5, 1'b0);

    // Reset while waiting for the writeback.
    do_req(5'd5, 5'd7, 5'd3, 1'b1);
    do_ops(0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wbwait_idle", 64'(req_ready), 64'(1));
    check("rst_wbwait_busy", 64'(busy), 64'(0));
    check("rst_wbwait_we", 64'(rf_we), 64'(0));
    check("rst_wbwait_wbrdy", 64'(wb_ready), 64'(0));

    // Reset while in WB: the pulse already underway completes, nothing after.
    do_req(5'd5, 5'd7, 5'd4, 1'b1);
    do_ops(0, 1'b1);
    wb_valid = 1'b1; wb_data = 32'hCAFE0001;
    exp_wr.push_back({5'd4, 32'hCAFE0001});
    shadow[4] = 32'hCAFE0001;
    tick();
    wb_valid = 1'b0; wb_data = '0;
    check("wb_state_we", 64'(rf_we), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wb_idle", 64'(req_ready), 64'(1));
    check("rst_wb_busy", 64'(busy), 64'(0));
    check("rst_wb_we", 64'(rf_we), 64'(0));
    tick();
    check("rst_wb_we_later", 64'(rf_we), 64'(0));

    // Normal operation resumes.
    do_req(5'd5, 5'd7, 5'd11, 1'b0);
    do_ops(0, 1'b0);

    repeat (2) tick();
    check("wr_queue_drained", 64'(exp_wr.size()), 64'(0));
    check("ops_queue_drained", 64'(exp_ops.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
